// File: rtl/multicycle_alu.sv
// Multicycle 8-bit ALU: single-cycle logic/arith ops, 8-step shift-add MUL
// and restoring DIV. Result, flags and a one-cycle done strobe are registered.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   start    in   request pulse, accepted only while busy=0
//   opcode   in   [2:0] operation select, sampled with start
//   a, b     in   [7:0] operands, sampled with start
//   busy     out  operation in progress
//   done     out  one-cycle result strobe
//   alu_out  out  [7:0] result, held until the next done
//   carry    out  carry/borrow/overflow/div-by-zero flag
//   zero     out  1 when alu_out == 8'h00
module multicycle_alu #(
    parameter logic [7:0] DIV_ZERO_RESULT = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] alu_out,
    output logic       carry,
    output logic       zero
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    // MUL: {partial product hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  out_q, out_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;

    logic        accept;
    logic [8:0]  res9;
    logic [8:0]  mul_sum;
    logic [15:0] mul_next;
    logic [8:0]  div_sh;
    logic        div_ge;
    logic [7:0]  div_rem;
    logic [15:0] div_next;
    logic        fin;
    logic [7:0]  fin_out;
    logic        fin_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            out_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        fin     = 1'b0;
        fin_out = 8'h00;
        fin_c   = 1'b0;

        // Single-cycle ops; bit 8 carries the carry/borrow flag.
        case (op_q)
            OP_ADD:  res9 = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  res9 = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  res9 = {1'b0, a_q & b_q};
            OP_OR:   res9 = {1'b0, a_q | b_q};
            OP_XOR:  res9 = {1'b0, a_q ^ b_q};
            OP_SHL:  res9 = {a_q, 1'b0};
            default: res9 = 9'd0;
        endcase

        mul_sum  = {1'b0, acc_q[15:8]}
                 + (acc_q[0] ? {1'b0, a_q} : 9'd0);
        mul_next = {mul_sum, acc_q[7:1]};

        div_sh   = acc_q[15:7];
        div_ge   = div_sh >= {1'b0, b_q};
        // Remainder after subtraction is < b, so 8 bits suffice.
        div_rem  = div_ge ? (div_sh[7:0] - b_q) : div_sh[7:0];
        div_next = {div_rem, acc_q[6:0], div_ge};

        // IDLE with busy_q set holds a captured single-cycle op.
        accept = start
               && ((state_q == IDLE && !busy_q)
               || state_q == DONE);

        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    fin     = 1'b1;
                    fin_out = res9[7:0];
                    fin_c   = res9[8];
                end
            end
            ITER: begin
                if (cnt_q == 4'd8) begin
                    fin = 1'b1;
                    if (op_q == OP_MUL) begin
                        fin_out = acc_q[7:0];
                        fin_c   = |acc_q[15:8];
                    end else if (b_q == 8'h00) begin
                        fin_out = DIV_ZERO_RESULT;
                        fin_c   = 1'b1;
                    end else begin
                        fin_out = acc_q[7:0];
                        fin_c   = 1'b0;
                    end
                end else begin
                    acc_d = (op_q == OP_MUL) ? mul_next : div_next;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fin) begin
            out_d   = fin_out;
            carry_d = fin_c;
            zero_d  = (fin_out == 8'h00);
            busy_d  = 1'b0;
            state_d = DONE;
        end

        if (accept) begin
            op_d   = opcode;
            a_d    = a;
            b_d    = b;
            busy_d = 1'b1;
            cnt_d  = 4'd0;
            acc_d  = (opcode == OP_MUL) ? {8'h00, b} : {8'h00, a};
            if (opcode == OP_MUL || opcode == OP_DIV) begin
                state_d = ITER;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = (state_q == DONE);
    assign alu_out = out_q;
    assign carry   = carry_q;
    assign zero    = zero_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter DIV_ZERO_RESULT, default 8'hFF, is the quotient driven on divide-by-zero.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; accepted only when busy=0.
REQ-005 opcode  input  3  operation select, sampled with start.
REQ-006 a  input  8  operand A, sampled with start.
REQ-007 b  input  8  operand B, sampled with start.
REQ-008 busy  output  1  operation in progress, no new request accepted.
REQ-009 done  output  1  one-cycle result strobe; drives the downstream register's save input.
REQ-010 alu_out  output  8  result; feeds the downstream register's data input.
REQ-011 carry  output  1  carry/borrow/overflow/error flag of the last result.
REQ-012 zero  output  1  1 when the last alu_out equals 8'h00.

Function
REQ-013 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV.
REQ-014 States SHALL be IDLE, ITER, DONE; ITER is used only by MUL and DIV.
REQ-015 start=1 at edge E0 in IDLE or DONE SHALL capture opcode, a, b and set busy=1 from E0.
REQ-016 start while busy=1 SHALL be ignored without affecting the operation in progress.
REQ-017 ADD/SUB/AND/OR/XOR/SHL SHALL register alu_out, flags and done=1 at E1, with busy=0 at E1.
REQ-018 MUL/DIV SHALL iterate at edges E1..E8 with one bit per edge, then register alu_out, flags and done=1 at E9, with busy=0 at E9.
REQ-019 done SHALL be high for exactly one cycle per accepted request; a start in the DONE cycle SHALL be accepted.
REQ-020 alu_out, carry and zero SHALL hold their values until the next done.
REQ-021 ADD: alu_out = (a+b)[7:0]; carry = bit 8 of the 9-bit sum.
REQ-022 SUB: alu_out = (a-b)[7:0] modulo 256; carry = 1 iff a<b (borrow).
REQ-023 AND/OR/XOR: bitwise result; carry = 0.
REQ-024 SHL: alu_out = {a[6:0],1'b0}; carry = a[7].
REQ-025 MUL: shift-add on unsigned operands; alu_out = product[7:0]; carry = 1 iff product[15:8] != 0.
REQ-026 DIV: restoring unsigned division; alu_out = quotient; remainder discarded; carry = 0.
REQ-027 DIV with b=0 SHALL still take 9 cycles, drive alu_out = DIV_ZERO_RESULT and carry=1.
REQ-028 zero SHALL be computed from the final registered alu_out for every opcode.
REQ-029 Operand inputs changing after E0 SHALL NOT affect the result.

Reset
REQ-030 reset=1 at any edge SHALL force IDLE and busy=0, done=0, alu_out=8'h00, carry=0, zero=0.
REQ-031 reset SHALL take priority over start on the same edge.
REQ-032 reset during ITER SHALL abort the operation with no done pulse.
REQ-033 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-034 ADD a=F0, b=20 -> at E1: alu_out=10, carry=1, zero=0, done=1 for one cycle, busy=0.
REQ-035 SUB a=05, b=05 -> alu_out=00, zero=1, carry=0; SUB a=03, b=05 -> alu_out=FE, carry=1.
REQ-036 MUL a=10, b=10 -> busy=1 for E0..E8, done at E9 with alu_out=00, carry=1, zero=1; start at E3 ignored.
REQ-037 DIV a=C8, b=07 -> alu_out=1C, carry=0 at E9; DIV a=55, b=00 -> alu_out=FF, carry=1 at E9.
REQ-038 MUL a=0F, b=0F with reset at E4 -> no done pulse, all outputs 0; next ADD 01+01 -> alu_out=02 at E1.
REQ-039 Back-to-back: XOR AA^FF with start held through its DONE cycle -> alu_out=55, and a second request is accepted in that cycle, producing a second done one cycle later.
